crc4_encoder: RTL and testbench

Generates the 8-bit CRC-4 codeword that the downstream CRC checker consumes. Accepts a 4-bit data nibble over a valid/ready handshake and computes the CRC-4 remainder bit-serially, MSB first, over 4 cycles. The generator polynomial is x^4+x+1. The block presents {data, crc} on a valid/ready output, with an optional error-injection control for exercising the checker's reject path.

---
 rtl/crc4_encoder.sv | 128 ++++++++++++
 tb/tb_crc4_encoder.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc4_encoder.sv
// crc4_encoder
//   Builds an 8-bit CRC-4 codeword {data, crc} from a 4-bit nibble. The
//   remainder is computed bit-serially, MSB first, over four cycles using the
//   generator x^4 + POLY (default x^4+x+1). An optional inject_err flag
//   inverts the codeword LSB so the downstream checker's reject path can be
//   exercised.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   in_valid    in_data is valid
//   in_ready    nibble can be accepted (IDLE only)
//   in_data     nibble to encode
//   inject_err  captured with in_data; flips out_data[0] of that codeword
//   out_valid   out_data holds a codeword
//   out_ready   downstream accepts out_data
//   out_data    codeword {data[3:0], crc[3:0]}
//   busy        block is not IDLE
//   cw_count    codewords delivered, wraps modulo 2^CNT_W
//
// state | meaning
// IDLE  | waiting for a nibble, in_ready high
// SHIFT | one data bit folded into crc per cycle, four cycles
// HOLD  | codeword presented, waiting for out_ready
module crc4_encoder #(
  parameter logic [3:0] POLY  = 4'b0011,
  parameter int         CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_data,
  input  logic             inject_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             busy,
  output logic [CNT_W-1:0] cw_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t     state, state_nx;
  logic [3:0] data_q;
  logic [3:0] crc_q;
  logic [1:0] cnt_q;
  logic       inject_q;

  logic [1:0] bit_sel;
  logic       d_bit;
  logic       fb;
  logic [3:0] crc_next;

  // MSB-first: cnt 0 selects data[3], cnt 3 selects data[0]
  assign bit_sel  = 2'd3 - cnt_q;
  assign d_bit    = data_q[bit_sel];
  assign fb       = crc_q[3] ^ d_bit;
  assign crc_next = {crc_q[2:0], 1'b0} ^ (fb ? POLY : 4'b0000);

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)      state_nx = SHIFT;
      SHIFT:   if (cnt_q == 2'd3) state_nx = HOLD;
      HOLD:    if (out_ready)     state_nx = IDLE;
      default:                    state_nx = IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    in_ready = (state == IDLE);
    busy     = (state != IDLE);
  end

  // datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q    <= 4'h0;
      inject_q  <= 1'b0;
      crc_q     <= 4'h0;
      cnt_q     <= 2'd0;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      cw_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            data_q   <= in_data;
            inject_q <= inject_err;
            crc_q    <= 4'h0;
            cnt_q    <= 2'd0;
          end
        end
        SHIFT: begin
          crc_q <= crc_next;
          cnt_q <= cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            // crc_next already holds the final remainder on this edge
            out_data  <= {data_q, crc_next ^ {3'b000, inject_q}};
            out_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            cw_count  <= cw_count + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_crc4_encoder.sv
module tb_crc4_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_data;
  logic       inject_err;
  logic       out_ready;

  logic        in_ready, out_valid, busy;
  logic [7:0]  out_data;
  logic [15:0] cw_count;

  logic       in_ready_s, out_valid_s, busy_s;
  logic [7:0] out_data_s;
  logic [2:0] cw_count_s;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  crc4_encoder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .inject_err(inject_err), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy), .cw_count(cw_count)
  );

  crc4_encoder #(.CNT_W(3)) dut_small (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_data(in_data), .inject_err(inject_err), .out_valid(out_valid_s),
    .out_ready(out_ready), .out_data(out_data_s), .busy(busy_s), .cw_count(cw_count_s)
  );

  // Polynomial long division by x^4+x+1 (0x13)
  function automatic logic [3:0] ref_rem(input logic [7:0] v);
    logic [7:0] r;
    r = v;
    for (int i = 7; i >= 4; i--)
      if (r[i]) r = r ^ (8'h13 << (i - 4));
    return r[3:0];
  endfunction

  function automatic logic [7:0] ref_cw(input logic [3:0] d, input logic inj);
    return {d, ref_rem({d, 4'h0}) ^ {3'b000, inj}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept a nibble, then count edges until out_valid (bounded); no handshake.
  task automatic send(input logic [3:0] d, input logic inj,
                      output int lat, output logic [7:0] cw);
    int w;
    w = 0;
    while (!in_ready && w < 20) begin tick(); w++; end
    in_data = d; inject_err = inj; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_data = 4'($urandom);
    inject_err = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin tick(); lat++; end
    cw = out_data;
  endtask

  task automatic release_cw();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_cnt++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    n_cmp++;
    if ({in_ready, out_valid, out_data, busy, cw_count} !== {1'b1, 1'b0, 8'h00, 1'b0, 16'h0}) begin
      n_bad++;
      $display("FAIL reset: got rdy=%b vld=%b data=%h busy=%b cnt=%0d, want 1 0 00 0 0",
               in_ready, out_valid, out_data, busy, cw_count);
    end
  endtask

  task automatic test_known_vectors();
    logic [3:0] din [6]  = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'hF};
    logic [7:0] dexp [6] = '{8'h00, 8'h13, 8'h26, 8'h4C, 8'h8B, 8'hF2};
    int lat;
    logic [7:0] cw;
    for (int i = 0; i < 6; i++) begin
      send(din[i], 1'b0, lat, cw);
      n_cmp++;
      if (cw !== dexp[i] || cw !== ref_cw(din[i], 1'b0)) begin
        n_bad++;
        $display("FAIL known_cw[%0d]: got %h want %h", i, cw, dexp[i]);
      end
      n_cmp++;
      if (lat !== 4) begin
        n_bad++;
        $display("FAIL latency[%0d]: got %0d edges want 4", i, lat);
      end
      release_cw();
    end
    n_cmp++;
    if (cw_count !== 16'd6 || cw_count !== 16'(exp_cnt)) begin
      n_bad++;
      $display("FAIL count_after_known: got %0d want 6", cw_count);
    end
  endtask

  task automatic test_inject_and_sweep();
    int lat;
    logic [7:0] cw;
    int sweep_bad;
    send(4'h8, 1'b1, lat, cw);
    n_cmp++;
    if (cw !== 8'h8A) begin
      n_bad++;
      $display("FAIL inject_cw: got %h want 8a", cw);
    end
    n_cmp++;
    if (ref_rem(cw) === 4'h0) begin
      n_bad++;
      $display("FAIL inject_rem: got remainder 0 want nonzero");
    end
    release_cw();
    sweep_bad = 0;
    for (int d = 0; d < 16; d++) begin
      send(4'(d), 1'b0, lat, cw);
      n_cmp++;
      if (ref_rem(cw) !== 4'h0 || cw !== ref_cw(4'(d), 1'b0)) begin
        n_bad++;
        $display("FAIL sweep[%0d]: got %h (rem %h) want %h", d, cw, ref_rem(cw), ref_cw(4'(d), 1'b0));
      end
      release_cw();
    end
  endtask

  task automatic test_random();
    int lat;
    logic [3:0] d;
    logic inj;
    logic [7:0] cw;
    for (int i = 0; i < 20; i++) begin
      d = 4'($urandom);
      inj = 1'($urandom);
      send(d, inj, lat, cw);
      n_cmp++;
      if (cw !== ref_cw(d, inj) || lat !== 4) begin
        n_bad++;
        $display("FAIL random[%0d]: got %h lat %0d want %h lat 4", i, cw, lat, ref_cw(d, inj));
      end
      release_cw();
    end
    n_cmp++;
    if (cw_count !== 16'(exp_cnt)) begin
      n_bad++;
      $display("FAIL count_after_random: got %0d want %0d", cw_count, exp_cnt);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [7:0] cw;
    logic [7:0] want;
    int bad;
    want = ref_cw(4'h5, 1'b0);
    send(4'h5, 1'b0, lat, cw);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_data = 4'h3;
      tick();
      if (out_data !== want || in_ready !== 1'b0 || out_valid !== 1'b1 || busy !== 1'b1) bad++;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL backpressure_hold: %0d bad cycles, data %h want %h stable", bad, out_data, want);
    end
    release_cw();
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || cw_count !== 16'(exp_cnt)) begin
      n_bad++;
      $display("FAIL backpressure_release: got vld=%b rdy=%b cnt=%0d want 0 1 %0d",
               out_valid, in_ready, cw_count, exp_cnt);
    end
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    n_cmp++;
    if (cw_count !== 16'(exp_cnt) || busy !== 1'b0 || out_data !== want) begin
      n_bad++;
      $display("FAIL backpressure_single: got cnt=%0d busy=%b data=%h want %0d 0 %h",
               cw_count, busy, out_data, exp_cnt, want);
    end
  endtask

  task automatic test_abort();
    int lat;
    logic [7:0] cw;
    do_reset();
    in_data = 4'h6; inject_err = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || cw_count !== 16'd0) begin
      n_bad++;
      $display("FAIL abort: got rdy=%b busy=%b vld=%b cnt=%0d want 1 0 0 0",
               in_ready, busy, out_valid, cw_count);
    end
    tick();
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_discard: got vld=%b busy=%b want 0 0", out_valid, busy);
    end
    send(4'h1, 1'b0, lat, cw);
    n_cmp++;
    if (cw !== 8'h13 || lat !== 4) begin
      n_bad++;
      $display("FAIL after_abort: got %h lat %0d want 13 lat 4", cw, lat);
    end
    release_cw();
    n_cmp++;
    if (cw_count !== 16'd1) begin
      n_bad++;
      $display("FAIL after_abort_count: got %0d want 1", cw_count);
    end
  endtask

  task automatic test_wrap();
    int lat;
    logic [7:0] cw;
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      send(4'($urandom), 1'b0, lat, cw);
      release_cw();
      n_cmp++;
      if (cw_count_s !== 3'(k % 8)) begin
        n_bad++;
        $display("FAIL wrap[%0d]: got %0d want %0d", k, cw_count_s, k % 8);
      end
    end
    n_cmp++;
    if (cw_count_s !== 3'd1 || cw_count !== 16'd9) begin
      n_bad++;
      $display("FAIL wrap_final: got small=%0d wide=%0d want 1 9", cw_count_s, cw_count);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 4'h0;
    inject_err = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_known_vectors();
    test_inject_and_sweep();
    test_random();
    test_backpressure();
    test_abort();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
